// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler sharing one external bit-serial adder between N_REQ
// requesters; streams operands LSB-first and returns the tagged W-bit sum.
module serial_add_scheduler #(
   parameter int W     = 8,
   parameter int N_REQ = 2,
   parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_vld,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   output logic [N_REQ-1:0]   req_rdy,
   output logic               ser_vld,
   output logic               ser_a,
   output logic               ser_b,
   output logic               ser_last,
   input  logic               ser_sum,
   output logic               res_vld,
   input  logic               res_rdy,
   output logic [W-1:0]       res_sum,
   output logic [ID_W-1:0]    res_id
);

   localparam int          CNT_W = $clog2(W);
   localparam int unsigned NR    = N_REQ;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   rr_ptr, id_q, grant_id, ptr_nxt;
   logic [CNT_W-1:0]  bit_cnt;
   logic [W-1:0]      sh_a, sh_b, sum_sh, sel_a, sel_b;
   logic              found, cnt_last;
   int unsigned       scan;

   // Search from the rr pointer upward, wrapping once around all requesters.
   always_comb begin
      found    = 1'b0;
      grant_id = '0;
      scan     = 0;
      for (int unsigned k = 0; k < NR; k++) begin
         scan = 32'(rr_ptr) + k;
         if (scan >= NR) scan = scan - NR;
         if (!found && req_vld[ID_W'(scan)]) begin
            found    = 1'b1;
            grant_id = ID_W'(scan);
         end
      end
   end

   always_comb begin
      sel_a   = req_a[grant_id*W +: W];
      sel_b   = req_b[grant_id*W +: W];
      ptr_nxt = (32'(grant_id) == NR - 1) ? '0 : grant_id + 1'b1;
      req_rdy = '0;
      if (rst && state == IDLE && found) req_rdy[grant_id] = 1'b1;
   end

   assign cnt_last = (bit_cnt == CNT_W'(W - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found)    state_nxt = SHIFT;
         SHIFT:   if (cnt_last) state_nxt = DONE;
         DONE:    if (res_rdy)  state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ser_vld  = (state == SHIFT);
      ser_a    = ser_vld & sh_a[0];
      ser_b    = ser_vld & sh_b[0];
      ser_last = ser_vld & cnt_last;
      res_vld  = (state == DONE);
      res_sum  = sum_sh;
      res_id   = id_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr  <= '0;
         id_q    <= '0;
         bit_cnt <= '0;
         sh_a    <= '0;
         sh_b    <= '0;
         sum_sh  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  sh_a    <= sel_a;
                  sh_b    <= sel_b;
                  id_q    <= grant_id;
                  rr_ptr  <= ptr_nxt;
                  bit_cnt <= '0;
               end
            end
            SHIFT: begin
               // Sum bits arrive LSB-first, so shift them in from the top.
               sh_a    <= sh_a >> 1;
               sh_b    <= sh_b >> 1;
               sum_sh  <= {ser_sum, sum_sh[W-1:1]};
               bit_cnt <= bit_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Directed bench for serial_add_scheduler with a behavioural bit-serial adder
// whose carry clears on vld&last and on system reset.
module tb_serial_add_scheduler;

   localparam int W     = 8;
   localparam int N_REQ = 2;
   localparam int ID_W  = 1;

   logic               clk = 1'b0;
   logic               rst;
   logic [N_REQ-1:0]   req_vld;
   logic [N_REQ*W-1:0] req_a, req_b;
   logic [N_REQ-1:0]   req_rdy;
   logic               ser_vld, ser_a, ser_b, ser_last, ser_sum;
   logic               res_vld, res_rdy;
   logic [W-1:0]       res_sum;
   logic [ID_W-1:0]    res_id;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   serial_add_scheduler #(.W(W), .N_REQ(N_REQ)) dut (
      .clk(clk), .rst(rst),
      .req_vld(req_vld), .req_a(req_a), .req_b(req_b), .req_rdy(req_rdy),
      .ser_vld(ser_vld), .ser_a(ser_a), .ser_b(ser_b), .ser_last(ser_last),
      .ser_sum(ser_sum),
      .res_vld(res_vld), .res_rdy(res_rdy), .res_sum(res_sum), .res_id(res_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic carry;
   assign ser_sum = ser_a ^ ser_b ^ carry;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         carry <= 1'b0;
      else if (ser_vld) carry <= ser_last ? 1'b0 : ((ser_a & ser_b) | (carry & (ser_a ^ ser_b)));
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Issue one operation from requester idx and check stream and result;
   // returns at the first DONE cycle without touching res_rdy.
   task automatic run_op(input int unsigned idx, input logic [1:0] vld,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] sum);
      int unsigned wc;
      logic [1:0]  exp_rdy;
      @(negedge clk);
      req_a[idx*W +: W] = a;
      req_b[idx*W +: W] = b;
      req_vld = vld;
      #1;
      wc = 0;
      while (req_rdy == '0 && wc < 30) begin
         @(negedge clk); #1;
         wc++;
      end
      exp_rdy = 2'b01;
      exp_rdy = exp_rdy << idx;
      chk("grant", 32'(req_rdy), 32'(exp_rdy));
      @(negedge clk);
      req_vld = '0;
      #1;
      for (int k = 0; k < W; k++) begin
         chk("ser_vld", 32'(ser_vld), 32'd1);
         chk("ser_a", 32'(ser_a), 32'(a[k]));
         chk("ser_b", 32'(ser_b), 32'(b[k]));
         chk("ser_last", 32'(ser_last), 32'(k == W - 1));
         @(negedge clk); #1;
      end
      chk("res_vld", 32'(res_vld), 32'd1);
      chk("res_sum", 32'(res_sum), 32'(sum));
      chk("res_id", 32'(res_id), idx);
      chk("ser_vld_done", 32'(ser_vld), 32'd0);
   endtask

   typedef struct {
      int unsigned idx;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [7:0]  sum;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int          gt[4];
      logic [1:0]  gm[4];
      int unsigned rid[4];
      logic [7:0]  rsum[4];
      int          ng, nr, wc;

      vecs[0] = '{0, 8'h5A, 8'h33, 8'h8D};
      vecs[1] = '{1, 8'hFF, 8'h01, 8'h00};
      vecs[2] = '{1, 8'h01, 8'h01, 8'h02};
      vecs[3] = '{0, 8'h80, 8'h80, 8'h00};
      vecs[4] = '{0, 8'h12, 8'h34, 8'h46};
      vecs[5] = '{1, 8'hAA, 8'h55, 8'hFF};

      rst = 1'b0; req_vld = '0; req_a = '0; req_b = '0; res_rdy = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      chk("rst_req_rdy", 32'(req_rdy), 32'd0);
      chk("rst_ser", 32'({ser_vld, ser_a, ser_b, ser_last}), 32'd0);
      chk("rst_res_vld", 32'(res_vld), 32'd0);
      chk("rst_res_sum", 32'(res_sum), 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
      @(negedge clk); rst = 1'b1;

      for (int i = 0; i < 6; i++)
         run_op(vecs[i].idx, 2'b01 << vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].sum);

      // Round robin with both requesters pending; pointer is 0 here.
      @(negedge clk);
      req_a = {8'h40, 8'h11}; req_b = {8'hC1, 8'h22}; req_vld = 2'b11;
      ng = 0; nr = 0; wc = 0;
      while (nr < 4 && wc < 100) begin
         #1;
         if (req_rdy != '0 && ng < 4) begin gm[ng] = req_rdy; gt[ng] = cyc; ng++; end
         if (res_vld) begin rid[nr] = 32'(res_id); rsum[nr] = res_sum; nr++; end
         @(negedge clk);
         wc++;
      end
      req_vld = '0;
      chk("rr_grants", ng, 4);
      chk("rr_results", nr, 4);
      for (int i = 0; i < 4; i++) begin
         chk("rr_grant_mask", 32'(gm[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
         chk("rr_res_id", rid[i], 32'(i % 2));
         chk("rr_res_sum", 32'(rsum[i]), (i % 2 == 0) ? 32'h33 : 32'h01);
         if (i > 0) chk("rr_spacing", gt[i] - gt[i-1], W + 2);
      end
      @(negedge clk); @(negedge clk);

      // Backpressure: hold DONE with a competing request pending.
      res_rdy = 1'b0;
      run_op(0, 2'b01, 8'h0F, 8'h01, 8'h10);
      req_a[W +: W] = 8'h20; req_b[W +: W] = 8'h03; req_vld = 2'b11;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk("bp_res_vld", 32'(res_vld), 32'd1);
         chk("bp_res_sum", 32'(res_sum), 32'h10);
         chk("bp_res_id", 32'(res_id), 32'd0);
         chk("bp_req_rdy", 32'(req_rdy), 32'd0);
         chk("bp_ser_vld", 32'(ser_vld), 32'd0);
      end
      @(negedge clk); res_rdy = 1'b1; #1;
      chk("bp_hs_vld", 32'(res_vld), 32'd1);
      @(negedge clk); #1;
      chk("bp_regrant", 32'(req_rdy), 32'd2);
      chk("bp_res_clr", 32'(res_vld), 32'd0);
      @(negedge clk); req_vld = '0;
      wc = 0;
      while (!res_vld && wc < 30) begin @(negedge clk); #1; wc++; end
      chk("bp_next_vld", 32'(res_vld), 32'd1);
      chk("bp_next_sum", 32'(res_sum), 32'h23);
      chk("bp_next_id", 32'(res_id), 32'd1);
      @(negedge clk); @(negedge clk);

      // Reset in the middle of a SHIFT.
      req_a[0 +: W] = 8'hF0; req_b[0 +: W] = 8'h0F; req_vld = 2'b01; #1;
      chk("mr_grant", 32'(req_rdy), 32'd1);
      @(negedge clk); req_vld = '0;
      @(negedge clk); @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mr_ser", 32'({ser_vld, ser_a, ser_b, ser_last}), 32'd0);
      chk("mr_res", 32'({res_vld, res_sum, res_id}), 32'd0);
      chk("mr_req_rdy", 32'(req_rdy), 32'd0);
      @(negedge clk); @(negedge clk); #1;
      chk("mr_no_res", 32'(res_vld), 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         chk("idle_quiet", 32'({req_rdy, ser_vld, res_vld}), 32'd0);
      end
      req_a[W +: W] = 8'h77; req_b[W +: W] = 8'h11;
      run_op(0, 2'b11, 8'h01, 8'h01, 8'h02);
      @(negedge clk); @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
